ex_muldiv: RTL and testbench

- Execute-stage iterative multiply/divide unit. Consumes the M-extension fields registered by the decode/execute pipeline register.
- Drives exe_stall back to that register, holding it while an operation is in flight, then presents a 32-bit result for one cycle.
- It is the producer end of the exe_stall handshake that the decode/execute register obeys.

---
 rtl/ex_muldiv.sv | 165 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ex_muldiv                                                          |
// | Brief  : Execute-stage iterative RV32M multiply/divide with exe_stall.      |
// |          Define MD_FASTMUL_EN for a single-cycle multiplier path.           |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            cpurst,
    input  logic            de2ex_MD_OP_ffout,
    input  logic [2:0]      de2ex_aluop_ffout,
    input  logic [XLEN-1:0] de2ex_rd_oprand1_ffout,
    input  logic [XLEN-1:0] de2ex_rd_oprand2_ffout,
    input  logic            memacc_stall,
    input  logic            mem2wb_exp_ffout,
    output logic            exe_stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_result_valid
);

    localparam int                c_CNT_W    = $clog2(ITER);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITER - 1);
    localparam logic [XLEN-1:0]   c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_rem;
    logic [XLEN-1:0]     r_quot;
    logic [XLEN-1:0]     r_dvsr;

    logic                w_launch, w_is_div, w_div_signed, w_div0, w_ovf, w_fast;
    logic                w_a_signed, w_b_signed, w_a_sgn, w_b_sgn;
    logic [XLEN-1:0]     w_a, w_b, w_a_mag, w_b_mag, w_fast_res;
    logic [2*XLEN-1:0]   w_acc_nxt, w_prod;
    logic [XLEN:0]       w_div_sh;
    logic                w_div_ge;
    logic [XLEN-1:0]     w_rem_nxt, w_quot_nxt, w_quot_f, w_rem_f, w_final;

    assign w_a          = de2ex_rd_oprand1_ffout;
    assign w_b          = de2ex_rd_oprand2_ffout;
    assign w_launch     = (r_state == c_IDLE) && de2ex_MD_OP_ffout && !mem2wb_exp_ffout;
    assign w_is_div     = de2ex_aluop_ffout[2];
    assign w_div_signed = de2ex_aluop_ffout[2] && !de2ex_aluop_ffout[0];
    assign w_a_signed   = (de2ex_aluop_ffout == 3'd1) || (de2ex_aluop_ffout == 3'd2) || w_div_signed;
    assign w_b_signed   = (de2ex_aluop_ffout == 3'd1) || w_div_signed;
    assign w_a_sgn      = w_a_signed && w_a[XLEN-1];
    assign w_b_sgn      = w_b_signed && w_b[XLEN-1];
    assign w_a_mag      = w_a_sgn ? -w_a : w_a;
    assign w_b_mag      = w_b_sgn ? -w_b : w_b;
    assign w_div0       = w_is_div && (w_b == '0);
    assign w_ovf        = w_div_signed && (w_a == c_MIN) && (w_b == '1);

`ifdef MD_FASTMUL_EN
    logic signed [2*XLEN-1:0] w_fa, w_fb;
    logic        [2*XLEN-1:0] w_fast_prod;
    assign w_fa        = {{XLEN{w_a_sgn}}, w_a};
    assign w_fb        = {{XLEN{w_b_sgn}}, w_b};
    assign w_fast_prod = w_fa * w_fb;
    assign w_fast      = w_div0 || w_ovf || !w_is_div;
`else
    assign w_fast      = w_div0 || w_ovf;
`endif

    always_comb begin
        w_fast_res = '0;
        if (w_div0)
            w_fast_res = de2ex_aluop_ffout[1] ? w_a : '1;
        else if (w_ovf)
            w_fast_res = de2ex_aluop_ffout[1] ? '0 : c_MIN;
`ifdef MD_FASTMUL_EN
        else if (de2ex_aluop_ffout == 3'd0)
            w_fast_res = w_fast_prod[XLEN-1:0];
        else
            w_fast_res = w_fast_prod[2*XLEN-1:XLEN];
`endif
    end

    // One shift-add step and one restoring-divide step per BUSY cycle.
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_div_sh   = {r_rem, r_quot[XLEN-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_dvsr};
    assign w_rem_nxt  = w_div_ge ? XLEN'(w_div_sh - {1'b0, r_dvsr}) : w_div_sh[XLEN-1:0];
    assign w_quot_nxt = {r_quot[XLEN-2:0], w_div_ge};
    assign w_quot_f   = r_neg ? -w_quot_nxt : w_quot_nxt;
    assign w_rem_f    = r_neg ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'd0:         w_final = w_prod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:         w_final = w_prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:   w_final = w_quot_f;
            default:      w_final = w_rem_f;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (mem2wb_exp_ffout) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (de2ex_MD_OP_ffout) w_state_nxt = w_fast ? c_DONE : c_BUSY;
                c_BUSY:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_DONE;
                c_DONE:  if (!memacc_stall) w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            md_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch) begin
                r_op     <= de2ex_aluop_ffout;
                // Remainder takes the dividend's sign; everything else the XOR.
                r_neg    <= (de2ex_aluop_ffout[2] && de2ex_aluop_ffout[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
                r_cnt    <= '0;
                r_acc    <= '0;
                r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_rem    <= '0;
                r_quot   <= w_a_mag;
                r_dvsr   <= w_b_mag;
                if (w_fast)
                    md_result <= w_fast_res;
            end else if ((r_state == c_BUSY) && !mem2wb_exp_ffout) begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc    <= w_acc_nxt;
                r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                r_rem    <= w_rem_nxt;
                r_quot   <= w_quot_nxt;
                if (r_cnt == c_CNT_LAST)
                    md_result <= w_final;
            end
        end
    end

    assign exe_stall       = !cpurst && !mem2wb_exp_ffout &&
                             (((r_state == c_IDLE) && de2ex_MD_OP_ffout) || (r_state == c_BUSY));
    assign md_result_valid = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ex_muldiv                                                       |
// | Brief  : Vector table, random ops and hold/kill/reset sequences.            |
// | Rev    : 1.0 - initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        cpurst, md_op, memacc_stall, exp_flush;
    logic [2:0]  aluop;
    logic [31:0] op1, op2;
    logic        exe_stall, md_result_valid;
    logic [31:0] md_result;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk                    (clk),
        .cpurst                 (cpurst),
        .de2ex_MD_OP_ffout      (md_op),
        .de2ex_aluop_ffout      (aluop),
        .de2ex_rd_oprand1_ffout (op1),
        .de2ex_rd_oprand2_ffout (op2),
        .memacc_stall           (memacc_stall),
        .mem2wb_exp_ffout       (exp_flush),
        .exe_stall              (exe_stall),
        .md_result              (md_result),
        .md_result_valid        (md_result_valid)
    );

`ifdef MD_FASTMUL_EN
    localparam int c_MUL_STALL = 1;
`else
    localparam int c_MUL_STALL = 33;
`endif

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          stall;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_res = 32'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] ua, ub, up;
        logic        [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = 32'h0;
        case (op)
            3'd0: begin up = ua * ub; r = up[31:0]; end
            3'd1: begin sp = sa * sb; r = sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); r = sp[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFFFFFF;
                  else begin sp = sa / sb; r = sp[31:0]; end
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else begin sp = sa % sb; r = sp[31:0]; end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Launch one op, hold MD_OP through DONE, then drop it and confirm no relaunch.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall,
                         input int hold);
        int stalls = 0;
        int cyc    = 0;
        @(negedge clk);
        md_op = 1'b1; aluop = op; op1 = a; op2 = b;
        sb_q.push_back(exp_res);
        #1;
        while (!md_result_valid && cyc < 100) begin
            if (exe_stall) stalls++;
            @(negedge clk); #1;
            cyc++;
        end
        if (!md_result_valid) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: no result after %0d cycles, required within 100", name, cyc);
            void'(sb_q.pop_front());
        end else begin
            check({name, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
            check({name, " stall_in_done"}, {31'h0, exe_stall}, 32'h0);
            if (sb_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL %s scoreboard: got result %h, required none pending", name, md_result);
            end else begin
                check({name, " result"}, md_result, sb_q.pop_front());
            end
            last_res = exp_res;
            if (hold > 0) begin
                memacc_stall = 1'b1;
                for (int i = 1; i <= hold; i++) begin
                    @(negedge clk);
                    if (i == hold) memacc_stall = 1'b0;
                    #1;
                    check({name, " hold_valid"}, {31'h0, md_result_valid}, 32'h1);
                    check({name, " hold_result"}, md_result, exp_res);
                    check({name, " hold_stall"}, {31'h0, exe_stall}, 32'h0);
                end
            end
        end
        @(negedge clk);
        md_op = 1'b0;
        #1;
        check({name, " valid_drop"}, {31'h0, md_result_valid}, 32'h0);
        check({name, " no_relaunch"}, {31'h0, exe_stall}, 32'h0);
    endtask

    initial begin
        int seen;
        cpurst = 1'b1; md_op = 1'b1; aluop = 3'd0; op1 = 32'd7; op2 = 32'd3;
        memacc_stall = 1'b0; exp_flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset stall", {31'h0, exe_stall}, 32'h0);
        check("reset result", md_result, 32'h0);
        check("reset valid", {31'h0, md_result_valid}, 32'h0);
        md_op = 1'b0; cpurst = 1'b0;

        vq.push_back('{"mul_7x-3",       3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, c_MUL_STALL});
        vq.push_back('{"mulhu_max",      3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, c_MUL_STALL});
        vq.push_back('{"mulh_-1x-1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, c_MUL_STALL});
        vq.push_back('{"mulhsu_-1xmax",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, c_MUL_STALL});
        vq.push_back('{"div_-7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        vq.push_back('{"rem_-7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        vq.push_back('{"divu_100/7",     3'd5, 32'd100,      32'd7,        32'd14,       33});
        vq.push_back('{"remu_100/7",     3'd7, 32'd100,      32'd7,        32'd2,        33});
        vq.push_back('{"divu_by0",       3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vq.push_back('{"rem_by0",        3'd6, 32'h12345678, 32'd0,        32'h12345678, 1});
        vq.push_back('{"div_ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vq.push_back('{"rem_ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
        vq.push_back('{"divu_min/max",   3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});

        foreach (vq[i])
            do_op(vq[i].name, vq[i].op, vq[i].a, vq[i].b, vq[i].res, vq[i].stall, 0);

        for (int i = 0; i < 12; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            int          st;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 5) ? 32'h0 : $urandom;
            if (!rop[2])
                st = c_MUL_STALL;
            else if (rb == 0 || (!rop[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF))
                st = 1;
            else
                st = 33;
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), st, 0);
        end

        do_op("memacc_hold", 3'd5, 32'd100, 32'd7, 32'd14, 33, 3);

        // Flush while BUSY at counter 10.
        @(negedge clk);
        md_op = 1'b1; aluop = 3'd4; op1 = 32'd1000; op2 = 32'd3;
        repeat (11) @(negedge clk);
        exp_flush = 1'b1;
        #1;
        check("kill stall_same_cycle", {31'h0, exe_stall}, 32'h0);
        md_op = 1'b0;
        @(negedge clk);
        exp_flush = 1'b0;
        #1;
        check("kill valid", {31'h0, md_result_valid}, 32'h0);
        check("kill stall", {31'h0, exe_stall}, 32'h0);
        check("kill result_kept", md_result, last_res);
        seen = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (md_result_valid || exe_stall) seen = 1;
        end
        check("kill never_valid", 32'(seen), 32'h0);

        // Reset while BUSY at counter 20.
        @(negedge clk);
        md_op = 1'b1; aluop = 3'd3; op1 = 32'hDEADBEEF; op2 = 32'h12345678;
        repeat (21) @(negedge clk);
        cpurst = 1'b1;
        #1;
        check("rst_mid stall", {31'h0, exe_stall}, 32'h0);
        @(negedge clk);
        #1;
        check("rst_mid result", md_result, 32'h0);
        check("rst_mid valid", {31'h0, md_result_valid}, 32'h0);
        cpurst = 1'b0; md_op = 1'b0;
        #1;
        check("rst_mid idle_stall", {31'h0, exe_stall}, 32'h0);

        do_op("after_reset_remu", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
